// File: rtl/hamming_enc_serializer.sv
// rtl/hamming_enc_serializer.sv - serial-in Hamming(15,11) encoder with serial and parallel codeword out
// Define HAMMING_EXT_PARITY_EN for SECDED (16,11): overall parity appended as position 16.
module hamming_enc_serializer (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        dout_last,
`ifdef HAMMING_EXT_PARITY_EN
   output logic [15:0] cw,
`else
   output logic [14:0] cw,
`endif
   output logic        cw_valid
);

`ifdef HAMMING_EXT_PARITY_EN
   localparam int CW_W = 16;
`else
   localparam int CW_W = 15;
`endif
   localparam logic [4:0] LAST_IDX = 5'(CW_W - 1);

   typedef enum logic [1:0] {LOAD, ENCODE, SEND} state_t;

   state_t            state;
   logic [3:0]        load_cnt;
   logic [4:0]        send_cnt;
   logic [10:0]       data;
   logic [14:0]       base_cw;
   logic [CW_W-1:0]   cw_next;
   logic [CW_W-1:0]   cw_shift;

   // data[k] holds the k-th arrival once all 11 bits have shifted in
   function automatic logic [14:0] encode(input logic [10:0] d);
      logic [14:0] c;
      c     = '0;
      c[2]  = d[0];
      c[4]  = d[1];
      c[5]  = d[2];
      c[6]  = d[3];
      c[14:8] = d[10:4];
      c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
      c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
      c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
      c[7]  = ^c[14:8];
      return c;
   endfunction

   assign base_cw = encode(data);
`ifdef HAMMING_EXT_PARITY_EN
   assign cw_next = {^base_cw, base_cw};
`else
   assign cw_next = base_cw;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= LOAD;
         load_cnt <= '0;
         send_cnt <= '0;
         data     <= '0;
         cw       <= '0;
         cw_valid <= 1'b0;
      end else begin
         cw_valid <= 1'b0;
         if (en) begin
            case (state)
               LOAD: begin
                  if (din_valid) begin
                     data <= {din, data[10:1]};
                     if (load_cnt == 4'd10) begin
                        load_cnt <= '0;
                        state    <= ENCODE;
                     end else begin
                        load_cnt <= load_cnt + 4'd1;
                     end
                  end
               end
               ENCODE: begin
                  cw       <= cw_next;
                  cw_valid <= 1'b1;
                  send_cnt <= '0;
                  state    <= SEND;
               end
               SEND: begin
                  if (dout_ready) begin
                     if (send_cnt == LAST_IDX) begin
                        send_cnt <= '0;
                        state    <= LOAD;
                     end else begin
                        send_cnt <= send_cnt + 5'd1;
                     end
                  end
               end
               default: state <= LOAD;
            endcase
         end
      end
   end

   assign cw_shift   = cw >> send_cnt;
   assign din_ready  = (state == LOAD) && en;
   assign dout_valid = (state == SEND) && en;
   assign dout_last  = (state == SEND) && (send_cnt == LAST_IDX);
   assign dout       = (state == SEND) && cw_shift[0];

endmodule

// File: tb/tb_hamming_enc_serializer.sv
// tb/tb_hamming_enc_serializer.sv - directed self-checking bench for hamming_enc_serializer
module tb_hamming_enc_serializer;

`ifdef HAMMING_EXT_PARITY_EN
   localparam int CW_W = 16;
   localparam logic [15:0] EXP_ZERO = 16'h0000;
   localparam logic [15:0] EXP_ONES = 16'hFFFF;
   localparam logic [15:0] EXP_D0   = 16'h8007;
   localparam logic [15:0] EXP_D4   = 16'h8181;
   localparam logic [15:0] EXP_D01  = 16'h001E;
   localparam logic [15:0] EXP_D10  = 16'hC08B;
`else
   localparam int CW_W = 15;
   localparam logic [15:0] EXP_ZERO = 16'h0000;
   localparam logic [15:0] EXP_ONES = 16'h7FFF;
   localparam logic [15:0] EXP_D0   = 16'h0007;
   localparam logic [15:0] EXP_D4   = 16'h0181;
   localparam logic [15:0] EXP_D01  = 16'h001E;
   localparam logic [15:0] EXP_D10  = 16'h408B;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic            din;
   logic            din_valid;
   logic            din_ready;
   logic            dout;
   logic            dout_valid;
   logic            dout_ready;
   logic            dout_last;
   logic [CW_W-1:0] cw;
   logic            cw_valid;

   int total = 0;
   int bad   = 0;

   hamming_enc_serializer dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .cw         (cw),
      .cw_valid   (cw_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [10:0] d, input int drop_at);
      int  k = 0;
      int  guard = 0;
      bit  dropped = 0;
      while (k < 11 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (k == drop_at && !dropped) begin
            dropped   = 1;
            en        = 1'b0;
            din       = ~d[k];
            din_valid = 1'b1;
            repeat (3) begin
               #1;
               check("en_low_din_ready", din_ready, 0);
               check("en_low_dout_valid", dout_valid, 0);
               @(negedge clk);
            end
            en = 1'b1;
         end
         din       = d[k];
         din_valid = 1'b1;
         #1;
         if (din_ready) k++;
      end
      if (k < 11) check("load_timeout", k, 11);
      @(posedge clk);
      #1;
      din       = 1'b1;
      din_valid = 1'b1;
   endtask

   task automatic collect(input int stall_at, input int stop_after, input logic [15:0] exp,
                          output logic [15:0] got, output int n, output int last_pos,
                          output int first_at, output int pulses, output logic [15:0] cw_seen);
      int guard = 0;
      int stall = 0;
      bit done  = 0;
      got = '0; n = 0; last_pos = -1; first_at = -1; pulses = 0; cw_seen = '0;
      while (!done && guard < 300) begin
         @(negedge clk);
         guard++;
         if (n == stall_at && stall < 5) begin
            dout_ready = 1'b0;
            stall++;
            #1;
            check("stall_dout", dout, exp[n]);
            check("stall_dout_last", dout_last, 0);
         end else begin
            dout_ready = 1'b1;
            #1;
         end
         if (cw_valid) begin
            pulses++;
            cw_seen = 16'(cw);
         end
         if (dout_valid && first_at < 0) first_at = guard;
         if (dout_valid && dout_ready) begin
            got[n] = dout;
            if (dout_last) begin
               last_pos = n;
               done = 1;
            end
            n++;
            if (n == stop_after) done = 1;
         end
      end
      if (!done) check("collect_timeout", 0, 1);
      din_valid = 1'b0;
   endtask

   logic [15:0] got, cw_seen;
   int n, last_pos, first_at, pulses, stray;

   initial begin
      reset = 1'b1; en = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_last", dout_last, 0);
      check("rst_cw", 32'(cw), 0);
      check("rst_cw_valid", cw_valid, 0);
      reset = 1'b0;
      #1;
      check("rel_din_ready", din_ready, 1);

      // all zeros, also checks latency and pulse width
      load_word(11'h000, -1);
      collect(-1, 99, EXP_ZERO, got, n, last_pos, first_at, pulses, cw_seen);
      check("zero_cw", 32'(cw_seen), 32'(EXP_ZERO));
      check("zero_bits", 32'(got), 32'(EXP_ZERO));
      check("zero_count", n, CW_W);
      check("zero_last_pos", last_pos, CW_W - 1);
      check("zero_latency", first_at, 2);
      check("zero_cw_pulses", pulses, 1);

      load_word(11'h7FF, -1);
      collect(-1, 99, EXP_ONES, got, n, last_pos, first_at, pulses, cw_seen);
      check("ones_cw", 32'(cw_seen), 32'(EXP_ONES));
      check("ones_bits", 32'(got), 32'(EXP_ONES));
      check("ones_cw_hold", 32'(cw), 32'(EXP_ONES));

      load_word(11'h001, -1);
      collect(-1, 99, EXP_D0, got, n, last_pos, first_at, pulses, cw_seen);
      check("d0_cw", 32'(cw_seen), 32'(EXP_D0));
      check("d0_bits", 32'(got), 32'(EXP_D0));
      check("d0_last_pos", last_pos, CW_W - 1);

      // backpressure after the 4th transfer
      load_word(11'h010, -1);
      collect(4, 99, EXP_D4, got, n, last_pos, first_at, pulses, cw_seen);
      check("stall_cw", 32'(cw_seen), 32'(EXP_D4));
      check("stall_bits", 32'(got), 32'(EXP_D4));
      check("stall_count", n, CW_W);

      // reset after the 7th transfer
      load_word(11'h003, -1);
      collect(-1, 7, EXP_D01, got, n, last_pos, first_at, pulses, cw_seen);
      check("pre_rst_count", n, 7);
      check("pre_rst_bits", 32'(got[6:0]), 32'(EXP_D01[6:0]));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_dout_valid", dout_valid, 0);
      check("midrst_dout", dout, 0);
      check("midrst_dout_last", dout_last, 0);
      check("midrst_cw", 32'(cw), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_din_ready", din_ready, 1);
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (dout_valid || dout_last) stray++;
      end
      check("midrst_stray", stray, 0);
      load_word(11'h003, -1);
      collect(-1, 99, EXP_D01, got, n, last_pos, first_at, pulses, cw_seen);
      check("post_rst_cw", 32'(cw_seen), 32'(EXP_D01));
      check("post_rst_bits", 32'(got), 32'(EXP_D01));
      check("post_rst_count", n, CW_W);

      // enable drop in the middle of loading
      load_word(11'h400, 5);
      collect(-1, 99, EXP_D10, got, n, last_pos, first_at, pulses, cw_seen);
      check("en_cw", 32'(cw_seen), 32'(EXP_D10));
      check("en_bits", 32'(got), 32'(EXP_D10));
      check("en_count", n, CW_W);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
